// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
//   state_e     : sequencer FSM states
//   ADDR_*      : reconfiguration controller register addresses
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrMode,
    StWrK,
    StWrStart,
    StWaitLock
  } state_e;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_FRAC_K = 6'd7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (output resets to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Retunes the PLL between native and underclocked fractional-K settings by
// writing mode, K and start registers on the reconfiguration controller's
// management port, then waits for relock.
//   clk_50m          : free-running reference clock (keeps running during relock)
//   reset            : asynchronous active-low reset
//   sel_async        : requested setting, 0 native / 1 underclock (async)
//   pll_locked       : PLL lock indicator (async)
//   mgmt_waitrequest : management port stall
//   mgmt_write/address/writedata : management port write channel
//   busy             : sequence in progress
//   applied          : setting most recently programmed
//   done             : one-cycle pulse on successful relock
//   lock_err         : sticky relock timeout, cleared when the next sequence starts
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter logic [31:0] K_NATIVE     = 32'd3639383488,
  parameter logic [31:0] K_UNDER      = 32'd3268298314,
  parameter int unsigned LOCK_SETTLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        sel_async,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        applied,
  output logic        done,
  output logic        lock_err
);

  localparam logic [15:0] LockSettle  = 16'(LOCK_SETTLE);
  localparam logic [15:0] LockTimeout = 16'(LOCK_TIMEOUT);

  logic        sel_s;
  logic        lock_s;
  logic        sel_q;
  logic        tgt_q;
  logic        applied_q;
  logic        done_q;
  logic        lock_err_q;
  logic        write_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;
  logic [15:0] cnt_q;
  state_e      state_q;

  logic req_pending;
  logic accept;
  logic settled;
  logic timed_out;

  sync_2ff u_sync_sel (
    .clk_i  (clk_50m),
    .rst_ni (reset),
    .d_i    (sel_async),
    .q_o    (sel_s)
  );

  sync_2ff u_sync_lock (
    .clk_i  (clk_50m),
    .rst_ni (reset),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  // A request needs two equal samples so a toggle mid-flight never starts a
  // sequence on a value that is about to change again.
  assign req_pending = (sel_s == sel_q) && (sel_q != applied_q);
  assign accept      = write_q && !mgmt_waitrequest;
  assign settled     = cnt_q >= LockSettle;
  assign timed_out   = cnt_q == LockTimeout;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_s;
    end
  end

  // Relock counter: cleared on start-write acceptance, saturates at the timeout.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == StWrStart && accept) begin
      cnt_q <= '0;
    end else if (state_q == StWaitLock && !timed_out) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Write states enter with write_q low, which provides the one-cycle gap
  // between consecutive writes; the next cycle raises the strobe.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      addr_q     <= ADDR_MODE;
      data_q     <= '0;
      tgt_q      <= 1'b0;
      applied_q  <= 1'b0;
      done_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_pending) begin
            tgt_q      <= sel_q;
            lock_err_q <= 1'b0;
            write_q    <= 1'b1;
            addr_q     <= ADDR_MODE;
            data_q     <= '0;
            state_q    <= StWrMode;
          end
        end
        StWrMode: begin
          if (accept) begin
            write_q <= 1'b0;
            state_q <= StWrK;
          end
        end
        StWrK: begin
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_FRAC_K;
            data_q  <= tgt_q ? K_UNDER : K_NATIVE;
          end else if (accept) begin
            write_q <= 1'b0;
            state_q <= StWrStart;
          end
        end
        StWrStart: begin
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_START;
            data_q  <= '0;
          end else if (accept) begin
            write_q   <= 1'b0;
            applied_q <= tgt_q;
            state_q   <= StWaitLock;
          end
        end
        StWaitLock: begin
          if (settled && lock_s) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (timed_out) begin
            lock_err_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          write_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign busy           = (state_q != StIdle);
  assign applied        = applied_q;
  assign done           = done_q;
  assign lock_err       = lock_err_q;

endmodule
